// File: rtl/i2c_req_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : i2c_req_arbiter_if                                           |
// | Description : Requester/engine bundle between clients and i2c_req_arbiter. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ*16-1:0] i_req_data;
    logic [NUM_REQ-1:0]    o_req_ready;
    logic [NUM_REQ-1:0]    o_req_err;
    logic [NUM_REQ-1:0]    o_grant;
    logic                  o_busy;
    logic                  o_i2c_req;
    logic [15:0]           o_i2c_data;
    logic                  i_i2c_done;
    logic                  i_i2c_ack;

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_data, i_i2c_done, i_i2c_ack,
        output o_req_ready, o_req_err, o_grant, o_busy, o_i2c_req, o_i2c_data
    );

    // Requesters plus I2C engine side.
    modport master (
        output i_req_valid, i_req_data, i_i2c_done, i_i2c_ack,
        input  o_req_ready, o_req_err, o_grant, o_busy, o_i2c_req, o_i2c_data
    );
endinterface

`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : i2c_req_arbiter                                              |
// | Description : Round-robin arbiter sharing one I2C engine among requesters. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_req_arbiter #(
    parameter int          NUM_REQ     = 3,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  wire                i_clk,
    input  wire                i_rstn,
    i2c_req_arbiter_if.slave   bus
);

    localparam int                 c_idx_w    = $clog2(NUM_REQ);
    localparam logic [c_idx_w:0]   c_num_ext  = (c_idx_w + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_one      = NUM_REQ'(1);
    localparam logic [15:0]        c_tmo_last = TIMEOUT_CYC - 16'd1;

    typedef logic [c_idx_w-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [NUM_REQ-1:0] r_grant_q, w_grant_d;
    logic [15:0]        r_data_q,  w_data_d;
    idx_t               r_owner_q, w_owner_d;
    idx_t               r_last_q,  w_last_d;
    logic               r_err_q,   w_err_d;
    logic [15:0]        r_tmo_q,   w_tmo_d;

    logic [c_idx_w:0]   w_cand;
    idx_t               w_win_idx;
    logic               w_any;

    assign w_any = |bus.i_req_valid;

    // Walk candidates from lowest to highest priority so the nearest one
    // after last_grant is the final overwrite.
    always_comb begin
        w_cand    = '0;
        w_win_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = {1'b0, r_last_q} + (c_idx_w + 1)'(i);
            if (w_cand >= c_num_ext) begin
                w_cand = w_cand - c_num_ext;
            end
            if (bus.i_req_valid[w_cand[c_idx_w-1:0]]) begin
                w_win_idx = w_cand[c_idx_w-1:0];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_data_d  = r_data_q;
        w_owner_d = r_owner_q;
        w_last_d  = r_last_q;
        w_err_d   = r_err_q;
        w_tmo_d   = '0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_d = ST_ISSUE;
                    w_owner_d = w_win_idx;
                    w_grant_d = c_one << w_win_idx;
                    w_data_d  = bus.i_req_data[{w_win_idx, 4'b0000} +: 16];
                end
            end
            ST_ISSUE: begin
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmo_d = r_tmo_q + 16'd1;
                // A done in the timeout cycle still reports the engine's ack.
                if (bus.i_i2c_done) begin
                    w_state_d = ST_DONE;
                    w_err_d   = bus.i_i2c_ack;
                    w_last_d  = r_owner_q;
                end else if (r_tmo_q == c_tmo_last) begin
                    w_state_d = ST_DONE;
                    w_err_d   = 1'b1;
                    w_last_d  = r_owner_q;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_err_d   = 1'b0;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state_q <= ST_IDLE;
            r_grant_q <= '0;
            r_data_q  <= 16'h0000;
            r_owner_q <= '0;
            r_last_q  <= c_idx_w'(NUM_REQ - 1);
            r_err_q   <= 1'b0;
            r_tmo_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_data_q  <= w_data_d;
            r_owner_q <= w_owner_d;
            r_last_q  <= w_last_d;
            r_err_q   <= w_err_d;
            r_tmo_q   <= w_tmo_d;
        end
    end

    assign bus.o_busy      = (r_state_q != ST_IDLE);
    assign bus.o_i2c_req   = (r_state_q == ST_ISSUE);
    assign bus.o_grant     = r_grant_q;
    assign bus.o_i2c_data  = r_data_q;
    assign bus.o_req_ready = (r_state_q == ST_DONE) ? r_grant_q : '0;
    assign bus.o_req_err   = ((r_state_q == ST_DONE) && r_err_q) ? r_grant_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_req_arbiter                                           |
// | Description : Directed vector bench for i2c_req_arbiter.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_i2c_req_arbiter;

    logic clk;
    logic rstn;

    i2c_req_arbiter_if #(.NUM_REQ(3)) bus_m ();
    i2c_req_arbiter_if #(.NUM_REQ(3)) bus_t ();

    i2c_req_arbiter #(.NUM_REQ(3)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_m)
    );

    i2c_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(16'd8)) dut_tmo (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [47:0] data;
        int          delay;
        logic        ack;
        logic [2:0]  exp_grant;
        logic [15:0] exp_data;
        logic        exp_err;
        logic        hold;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req_m(output int lat);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus_m.o_i2c_req) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_req_t(output int lat);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus_t.o_i2c_req) begin
                lat = k;
                break;
            end
        end
    endtask

    // Called at a negedge; returns at the ready negedge (hold) or one cycle later.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bus_m.i_req_valid = v.valid;
        bus_m.i_req_data  = v.data;
        wait_req_m(lat);
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d_grant", idx), 64'(bus_m.o_grant), 64'(v.exp_grant));
        check($sformatf("v%0d_data_issue", idx), 64'(bus_m.o_i2c_data), 64'(v.exp_data));
        repeat (v.delay) @(negedge clk);
        bus_m.i_req_data = ~v.data;
        check($sformatf("v%0d_early_ready", idx), 64'(bus_m.o_req_ready), 64'd0);
        bus_m.i_i2c_done = 1'b1;
        bus_m.i_i2c_ack  = v.ack;
        @(negedge clk);
        bus_m.i_i2c_done = 1'b0;
        bus_m.i_i2c_ack  = 1'b0;
        check($sformatf("v%0d_ready", idx), 64'(bus_m.o_req_ready), 64'(v.exp_grant));
        check($sformatf("v%0d_err", idx), 64'(bus_m.o_req_err),
              64'(v.exp_err ? v.exp_grant : 3'b000));
        check($sformatf("v%0d_data_done", idx), 64'(bus_m.o_i2c_data), 64'(v.exp_data));
        if (!v.hold) begin
            bus_m.i_req_valid = '0;
            @(negedge clk);
            check($sformatf("v%0d_grant_clear", idx), 64'(bus_m.o_grant), 64'd0);
            check($sformatf("v%0d_idle", idx), 64'(bus_m.o_busy), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic seen;

        // Requester 1 alone, NACK on 2, round-robin 0,1,2,0 with valid held, wrap cases.
        vecs[0] = '{3'b010, {16'h2222, 16'h3A55, 16'h1111}, 10, 1'b0, 3'b010, 16'h3A55, 1'b0, 1'b0, 1};
        vecs[1] = '{3'b100, {16'hC3F0, 16'h0000, 16'h0000},  3, 1'b1, 3'b100, 16'hC3F0, 1'b1, 1'b0, 1};
        vecs[2] = '{3'b111, {16'hAAA2, 16'hAAA1, 16'hAAA0},  4, 1'b0, 3'b001, 16'hAAA0, 1'b0, 1'b1, 1};
        vecs[3] = '{3'b111, {16'hAAA2, 16'hAAA1, 16'hAAA0},  4, 1'b0, 3'b010, 16'hAAA1, 1'b0, 1'b1, 2};
        vecs[4] = '{3'b111, {16'hAAA2, 16'hAAA1, 16'hAAA0},  4, 1'b0, 3'b100, 16'hAAA2, 1'b0, 1'b1, 2};
        vecs[5] = '{3'b111, {16'hAAA2, 16'hAAA1, 16'hAAA0},  4, 1'b0, 3'b001, 16'hAAA0, 1'b0, 1'b0, 2};
        vecs[6] = '{3'b101, {16'h5502, 16'h5501, 16'h5500},  1, 1'b0, 3'b100, 16'h5502, 1'b0, 1'b0, 1};
        vecs[7] = '{3'b011, {16'h6602, 16'h6601, 16'h6600},  2, 1'b1, 3'b001, 16'h6600, 1'b1, 1'b0, 1};
        vecs[8] = '{3'b110, {16'h9902, 16'h9901, 16'h9900},  5, 1'b0, 3'b010, 16'h9901, 1'b0, 1'b0, 1};

        rstn = 1'b0;
        bus_m.i_req_valid = '0; bus_m.i_req_data = '0;
        bus_m.i_i2c_done  = 1'b0; bus_m.i_i2c_ack = 1'b0;
        bus_t.i_req_valid = '0; bus_t.i_req_data = '0;
        bus_t.i_i2c_done  = 1'b0; bus_t.i_i2c_ack = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_grant", 64'(bus_m.o_grant), 64'd0);
        check("rst_busy",  64'(bus_m.o_busy), 64'd0);
        check("rst_req",   64'(bus_m.o_i2c_req), 64'd0);
        check("rst_data",  64'(bus_m.o_i2c_data), 64'd0);
        check("rst_ready", 64'({bus_m.o_req_ready, bus_m.o_req_err}), 64'd0);

        // First vector starts on the same negedge reset is released.
        rstn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Stray done in IDLE and ISSUE, then valid dropped after grant.
        bus_m.i_i2c_done = 1'b1; bus_m.i_i2c_ack = 1'b1;
        @(negedge clk);
        bus_m.i_i2c_done = 1'b0; bus_m.i_i2c_ack = 1'b0;
        check("stray_idle_busy",  64'(bus_m.o_busy), 64'd0);
        check("stray_idle_ready", 64'(bus_m.o_req_ready), 64'd0);
        bus_m.i_req_valid = 3'b001;
        bus_m.i_req_data  = {16'h0000, 16'h0000, 16'hBEEF};
        wait_req_m(lat);
        check("stray_lat", 64'(lat), 64'd1);
        bus_m.i_i2c_done = 1'b1; bus_m.i_i2c_ack = 1'b1;
        @(negedge clk);
        bus_m.i_i2c_done = 1'b0; bus_m.i_i2c_ack = 1'b0;
        check("stray_issue_busy",  64'(bus_m.o_busy), 64'd1);
        check("stray_issue_ready", 64'(bus_m.o_req_ready), 64'd0);
        bus_m.i_req_valid = '0;
        repeat (3) @(negedge clk);
        bus_m.i_i2c_done = 1'b1;
        @(negedge clk);
        bus_m.i_i2c_done = 1'b0;
        check("drop_ready", 64'(bus_m.o_req_ready), 64'd1);
        check("drop_err",   64'(bus_m.o_req_err), 64'd0);
        check("drop_data",  64'(bus_m.o_i2c_data), 64'hBEEF);
        @(negedge clk);

        // Reset in the middle of WAIT for requester 1.
        bus_m.i_req_valid = 3'b110;
        bus_m.i_req_data  = {16'h7702, 16'h7701, 16'h7700};
        wait_req_m(lat);
        check("rw_grant", 64'(bus_m.o_grant), 64'b010);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rw_grant_async", 64'(bus_m.o_grant), 64'd0);
        check("rw_busy_async",  64'(bus_m.o_busy), 64'd0);
        check("rw_data_async",  64'(bus_m.o_i2c_data), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus_m.o_req_ready != 3'b000) seen = 1'b1;
        end
        check("rw_no_ready", 64'(seen), 64'd0);
        bus_m.i_req_valid = 3'b111;
        rstn = 1'b1;
        wait_req_m(lat);
        check("rw_lat", 64'(lat), 64'd1);
        check("rw_next_grant", 64'(bus_m.o_grant), 64'b001);
        check("rw_next_data",  64'(bus_m.o_i2c_data), 64'h7700);
        repeat (2) @(negedge clk);
        bus_m.i_i2c_done = 1'b1;
        @(negedge clk);
        bus_m.i_i2c_done = 1'b0;
        check("rw_next_ready", 64'(bus_m.o_req_ready), 64'b001);
        bus_m.i_req_valid = '0;
        @(negedge clk);

        // Timeout with TIMEOUT_CYC = 8: ready nine cycles after the start pulse.
        bus_t.i_req_valid = 3'b001;
        bus_t.i_req_data  = {16'h0000, 16'h0000, 16'h0808};
        wait_req_t(lat);
        check("tmo_lat", 64'(lat), 64'd1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_t.o_req_ready != 3'b000) begin
                n = k;
                break;
            end
        end
        check("tmo_cycles", 64'(n), 64'd9);
        check("tmo_ready",  64'(bus_t.o_req_ready), 64'b001);
        check("tmo_err",    64'(bus_t.o_req_err), 64'b001);
        bus_t.i_req_valid = '0;
        @(negedge clk);

        // Done in the same cycle as the timeout: ack decides err.
        bus_t.i_req_valid = 3'b010;
        wait_req_t(lat);
        repeat (8) @(negedge clk);
        check("tmo_tie_early", 64'(bus_t.o_req_ready), 64'd0);
        bus_t.i_i2c_done = 1'b1; bus_t.i_i2c_ack = 1'b0;
        @(negedge clk);
        bus_t.i_i2c_done = 1'b0;
        check("tmo_tie_ready", 64'(bus_t.o_req_ready), 64'b010);
        check("tmo_tie_err",   64'(bus_t.o_req_err), 64'b000);
        bus_t.i_req_valid = '0;
        @(negedge clk);
        check("tmo_tie_idle", 64'(bus_t.o_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
